// File: rtl/data_gen_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_gen_param_if : TX FIFO write port (data, delimiter, strobe) |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface data_gen_param_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dout;
  logic [1:0]        delimeter;
  logic              wr_en;
  logic              tx_fifo_pfull;

  modport master (
    output dout,
    output delimeter,
    output wr_en,
    input  tx_fifo_pfull
  );

  modport slave (
    input  dout,
    input  delimeter,
    input  wr_en,
    output tx_fifo_pfull
  );
endinterface
`default_nettype wire

// File: rtl/data_gen_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_gen_param : framed test-pattern source for the TX FIFO      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module data_gen_param #(
  parameter int              DATA_W     = 16,
  parameter int              FRAME_LEN  = 8,
  parameter int              NUM_FRAMES = 4,
  parameter int              GAP_CYC    = 2,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(16'hACE1)
) (
  input  logic             clk_usr,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [1:0]       mode,
  data_gen_param_if.master fifo,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  localparam logic [15:0]       c_word_last  = 16'(FRAME_LEN - 1);
  localparam logic [15:0]       c_frame_last = 16'(NUM_FRAMES - 1);
  localparam logic [15:0]       c_gap_last   = 16'(GAP_CYC - 1);
  localparam bit                c_gap_zero   = (GAP_CYC == 0);
  localparam logic [DATA_W-1:0] c_alt_init   = {(DATA_W/2){2'b01}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_pat;
  logic [DATA_W-1:0] w_pat_init;
  logic [DATA_W-1:0] w_pat_adv;
  logic [15:0]       r_word_idx;
  logic [15:0]       r_frame_idx;
  logic [15:0]       r_gap_cnt;
  logic              r_stop_pend;

  logic w_idle;
  logic w_start;
  logic w_issue;
  logic w_last_word;
  logic w_last_frame;
  logic w_eop_issue;
  logic w_stop_any;

  assign w_idle       = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start      = w_idle && start;
  assign w_issue      = (r_state == ST_SEND) && !fifo.tx_fifo_pfull;
  assign w_last_word  = (r_word_idx == c_word_last);
  assign w_last_frame = (r_frame_idx == c_frame_last);
  assign w_eop_issue  = w_issue && w_last_word;
  assign w_stop_any   = r_stop_pend || stop;

  always_comb begin
    w_pat_init = '0;
    case (mode)
      2'b00:   w_pat_init = '0;
      2'b01:   w_pat_init = DATA_W'(1);
      2'b10:   w_pat_init = LFSR_SEED;
      default: w_pat_init = c_alt_init;
    endcase
  end

  always_comb begin
    w_pat_adv = r_pat;
    case (r_mode)
      2'b00:   w_pat_adv = r_pat + DATA_W'(1);
      2'b01:   w_pat_adv = {r_pat[DATA_W-2:0], r_pat[DATA_W-1]};
      2'b10:   w_pat_adv = (r_pat >> 1) ^ (r_pat[0] ? LFSR_TAPS : '0);
      default: w_pat_adv = ~r_pat;
    endcase
  end

  always_ff @(posedge clk_usr or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // A stop arriving on the EOP edge itself still ends the run there.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_eop_issue) begin
          if (w_stop_any || (w_last_frame && !loop_en)) w_state_next = ST_DONE;
          else if (c_gap_zero)                          w_state_next = ST_SEND;
          else                                          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_stop_any)                    w_state_next = ST_DONE;
        else if (r_gap_cnt == c_gap_last)  w_state_next = ST_SEND;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usr or posedge rst) begin
    if (rst) begin
      r_mode         <= 2'b00;
      r_pat          <= '0;
      r_word_idx     <= '0;
      r_frame_idx    <= '0;
      r_gap_cnt      <= '0;
      r_stop_pend    <= 1'b0;
      fifo.dout      <= '0;
      fifo.delimeter <= 2'b00;
      fifo.wr_en     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      fifo.wr_en <= w_issue;
      r_gap_cnt  <= (r_state == ST_GAP) ? r_gap_cnt + 16'd1 : 16'd0;

      if (w_idle) r_stop_pend <= 1'b0;
      else if (stop) r_stop_pend <= 1'b1;

      if (w_start) begin
        r_mode      <= mode;
        r_pat       <= w_pat_init;
        r_word_idx  <= '0;
        r_frame_idx <= '0;
        frame_cnt   <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
      end else if (r_state == ST_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if (w_issue) begin
        fifo.dout      <= r_pat;
        fifo.delimeter <= {w_last_word, (r_word_idx == 16'd0)};
        r_pat          <= w_pat_adv;
        if (w_last_word) begin
          r_word_idx  <= '0;
          r_frame_idx <= w_last_frame ? 16'd0 : r_frame_idx + 16'd1;
          if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
        end else begin
          r_word_idx <= r_word_idx + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
